// File: rtl/mux_n_to_1_scan.sv
// N-channel, WIDTH-bit multiplexer with registered output. Channels are picked
// by `sel` (manual) or by an internal round-robin sequencer that holds each channel DWELL cycles (scan).
//
// state  | meaning
// MANUAL | channel taken from sel; ptr/cnt parked at 0
// SCAN   | channel taken from ptr; cnt counts cycles spent on the current channel
module mux_n_to_1_scan #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int DWELL = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  input  logic               en,
  output logic [WIDTH-1:0]   out,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  output logic               scan_wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic [SEL_W-1:0]   cur_ptr;
  logic [CNT_W-1:0]   cur_cnt;
  logic [WIDTH-1:0]   man_data;
  logic [WIDTH-1:0]   scan_data;
  logic               sel_ok;
  logic               dwell_done;
  logic               ptr_last;

  // Entering scan from manual always starts fresh at channel 0 with a full dwell.
  always_comb begin
    cur_ptr   = (state == SCAN) ? ptr : '0;
    cur_cnt   = (state == SCAN) ? cnt : '0;
    man_data  = '0;
    scan_data = '0;
    sel_ok    = (int'(sel) < N);
    for (int k = 0; k < N; k++) begin
      if (int'(sel) == k)
        man_data = in_bus[k*WIDTH +: WIDTH];
      if (int'(cur_ptr) == k)
        scan_data = in_bus[k*WIDTH +: WIDTH];
    end
    dwell_done = (cur_cnt == CNT_W'(DWELL - 1));
    ptr_last   = (cur_ptr == SEL_W'(N - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= MANUAL;
      ptr       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
    end else if (!en) begin
      scan_wrap <= 1'b0;
    end else if (mode) begin
      state     <= SCAN;
      out       <= scan_data;
      out_ch    <= cur_ptr;
      out_valid <= 1'b1;
      if (dwell_done) begin
        cnt       <= '0;
        ptr       <= ptr_last ? '0 : cur_ptr + SEL_W'(1);
        scan_wrap <= ptr_last;
      end else begin
        cnt       <= cur_cnt + CNT_W'(1);
        ptr       <= cur_ptr;
        scan_wrap <= 1'b0;
      end
    end else begin
      // Leaving scan (or staying manual): a pending dwell expiry is discarded.
      state     <= MANUAL;
      ptr       <= '0;
      cnt       <= '0;
      scan_wrap <= 1'b0;
      if (sel_ok) begin
        out       <= man_data;
        out_ch    <= sel;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// Directed bench for mux_n_to_1_scan: a 4-channel DWELL=2 instance and a
// 3-channel DWELL=1 instance exercising the non-power-of-2 select range.
module tb_mux_n_to_1_scan;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] in_a;
  logic [1:0]  sel_a;
  logic        mode_a, en_a;
  logic [7:0]  out_a;
  logic [1:0]  ch_a;
  logic        valid_a, wrap_a;

  logic [23:0] in_b;
  logic [1:0]  sel_b;
  logic        mode_b, en_b;
  logic [7:0]  out_b;
  logic [1:0]  ch_b;
  logic        valid_b, wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_to_1_scan #(.WIDTH(8), .N(4), .DWELL(2)) dut_a (
    .clk(clk), .reset(reset), .in_bus(in_a), .sel(sel_a), .mode(mode_a), .en(en_a),
    .out(out_a), .out_ch(ch_a), .out_valid(valid_a), .scan_wrap(wrap_a)
  );

  mux_n_to_1_scan #(.WIDTH(8), .N(3), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset), .in_bus(in_b), .sel(sel_b), .mode(mode_b), .en(en_b),
    .out(out_b), .out_ch(ch_b), .out_valid(valid_b), .scan_wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] o, input logic [1:0] c,
                       input logic v, input logic w);
    chk({tag, ".out"}, 32'(out_a), 32'(o));
    chk({tag, ".ch"}, 32'(ch_a), 32'(c));
    chk({tag, ".valid"}, 32'(valid_a), 32'(v));
    chk({tag, ".wrap"}, 32'(wrap_a), 32'(w));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] o, input logic [1:0] c,
                       input logic v, input logic w);
    chk({tag, ".out"}, 32'(out_b), 32'(o));
    chk({tag, ".ch"}, 32'(ch_b), 32'(c));
    chk({tag, ".valid"}, 32'(valid_b), 32'(v));
    chk({tag, ".wrap"}, 32'(wrap_b), 32'(w));
  endtask

  // one active edge, then settle to the falling edge before looking
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] man_out  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] scan_out [9] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11};
  logic [1:0] scan_ch  [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
  logic       scan_wr  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset  = 1'b1;
    in_a   = 32'h44332211;
    sel_a  = 2'd0;
    mode_a = 1'b0;
    en_a   = 1'b1;
    in_b   = 24'hCCBBAA;
    sel_b  = 2'd0;
    mode_b = 1'b0;
    en_b   = 1'b1;

    @(negedge clk);
    chk_a("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      step();
      chk_a($sformatf("manual%0d", i), man_out[i], 2'(i), 1'b1, 1'b0);
    end

    mode_a = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk_a($sformatf("scan%0d", i), scan_out[i], scan_ch[i], 1'b1, scan_wr[i]);
    end

    // async reset between edges, mid-dwell
    #2 reset = 1'b1;
    #1 chk_a("reset_mid_scan", 8'h00, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    step(); chk_a("frz_pre0", 8'h11, 2'd0, 1'b1, 1'b0);
    step(); chk_a("frz_pre1", 8'h11, 2'd0, 1'b1, 1'b0);
    step(); chk_a("frz_pre2", 8'h22, 2'd1, 1'b1, 1'b0);
    en_a  = 1'b0;
    sel_a = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("frz_hold%0d", i), 8'h22, 2'd1, 1'b1, 1'b0);
    end
    en_a = 1'b1;
    step(); chk_a("frz_resume0", 8'h22, 2'd1, 1'b1, 1'b0);
    step(); chk_a("frz_resume1", 8'h33, 2'd2, 1'b1, 1'b0);

    // second cycle on ch2 sees the new data
    in_a = 32'h445A2211;
    step(); chk_a("live_5a", 8'h5A, 2'd2, 1'b1, 1'b0);
    step(); chk_a("pre_switch", 8'h44, 2'd3, 1'b1, 1'b0);
    // this edge would wrap 3->0, but the mode change wins
    mode_a = 1'b0;
    sel_a  = 2'd3;
    step(); chk_a("switch_manual", 8'h44, 2'd3, 1'b1, 1'b0);
    mode_a = 1'b1;
    step(); chk_a("rescan0", 8'h11, 2'd0, 1'b1, 1'b0);
    step(); chk_a("rescan1", 8'h11, 2'd0, 1'b1, 1'b0);
    step(); chk_a("rescan2", 8'h22, 2'd1, 1'b1, 1'b0);

    // N=3: ch0=AA ch1=BB ch2=CC, DWELL=1
    sel_b = 2'd1;
    step(); chk_b("n3_sel1", 8'hBB, 2'd1, 1'b1, 1'b0);
    sel_b = 2'd3;
    step(); chk_b("n3_sel3", 8'hBB, 2'd1, 1'b0, 1'b0);
    sel_b = 2'd2;
    step(); chk_b("n3_sel2", 8'hCC, 2'd2, 1'b1, 1'b0);
    mode_b = 1'b1;
    step(); chk_b("n3_scan0", 8'hAA, 2'd0, 1'b1, 1'b0);
    step(); chk_b("n3_scan1", 8'hBB, 2'd1, 1'b1, 1'b0);
    step(); chk_b("n3_scan2", 8'hCC, 2'd2, 1'b1, 1'b1);
    step(); chk_b("n3_scan3", 8'hAA, 2'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
